hit_score_ctl: RTL and testbench

Consumer side of the projectile position stream: takes the shot position driven by the projectile controller plus the target position, detects shot/target overlap once per frame, and produces the `score` and a `shot_done` return pulse that ends the flight. Sits between the projectile controller, the target mover and the score/overlay drawing stage, all in the pixel clock domain.

---
 rtl/game_pkg.sv | 24 ++
 rtl/hit_score_ctl_if.sv | 37 +++
 rtl/rect_overlap.sv | 44 ++++
 rtl/hit_score_ctl.sv | 155 +++++++++++++++
 tb/tb_hit_score_ctl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// game_pkg
// Shared types and geometry defaults for the shot/target game datapath.
// The draw modules use the same rectangle sizes, so they live here.
//   POS_W          : width of every screen coordinate
//   *_DEF          : default shot/target rectangle sizes in pixels
//   state_e        : hit/score controller states
package game_pkg;

  localparam int POS_W        = 12;
  localparam int SHOT_W_DEF   = 8;
  localparam int SHOT_H_DEF   = 20;
  localparam int TARGET_W_DEF = 64;
  localparam int TARGET_H_DEF = 32;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HOLD,
    ST_OVER
  } state_e;

endpackage

// File: rtl/hit_score_ctl_if.sv
// hit_score_ctl_if
// Bundle between the projectile controller / target mover (master side)
// and the hit/score controller (slave side).
//   master drives : frame_tick, shot_valid, shot_xpos, shot_ypos,
//                   target_xpos, target_ypos, new_game
//   slave drives  : score, miss_cnt, hit, shot_done, hit_flash, game_over
interface hit_score_ctl_if;
  import game_pkg::*;

  logic        frame_tick;
  logic        shot_valid;
  pos_t        shot_xpos;
  pos_t        shot_ypos;
  pos_t        target_xpos;
  pos_t        target_ypos;
  logic        new_game;

  logic [11:0] score;
  logic [3:0]  miss_cnt;
  logic        hit;
  logic        shot_done;
  logic        hit_flash;
  logic        game_over;

  modport master (
    output frame_tick, shot_valid, shot_xpos, shot_ypos,
           target_xpos, target_ypos, new_game,
    input  score, miss_cnt, hit, shot_done, hit_flash, game_over
  );

  modport slave (
    input  frame_tick, shot_valid, shot_xpos, shot_ypos,
           target_xpos, target_ypos, new_game,
    output score, miss_cnt, hit, shot_done, hit_flash, game_over
  );

endinterface

// File: rtl/rect_overlap.sv
// rect_overlap
// Combinational test for two axis-aligned rectangles sharing at least one
// pixel. Edges are inclusive. Right/bottom edges are formed one bit wider
// than the positions so a rectangle near x=4095 does not wrap to the left.
//   ax, ay   : rectangle A top-left (A_W x A_H)
//   bx, by   : rectangle B top-left (B_W x B_H)
//   overlap  : 1 when the rectangles intersect
module rect_overlap
  import game_pkg::*;
#(
  parameter int A_W = SHOT_W_DEF,
  parameter int A_H = SHOT_H_DEF,
  parameter int B_W = TARGET_W_DEF,
  parameter int B_H = TARGET_H_DEF
) (
  input  pos_t ax,
  input  pos_t ay,
  input  pos_t bx,
  input  pos_t by,
  output logic overlap
);

  localparam logic [POS_W:0] A_W_M1 = (POS_W+1)'(A_W - 1);
  localparam logic [POS_W:0] A_H_M1 = (POS_W+1)'(A_H - 1);
  localparam logic [POS_W:0] B_W_M1 = (POS_W+1)'(B_W - 1);
  localparam logic [POS_W:0] B_H_M1 = (POS_W+1)'(B_H - 1);

  logic [POS_W:0] ax_e, ay_e, bx_e, by_e;
  logic [POS_W:0] a_right, a_bottom, b_right, b_bottom;

  always_comb begin
    ax_e     = {1'b0, ax};
    ay_e     = {1'b0, ay};
    bx_e     = {1'b0, bx};
    by_e     = {1'b0, by};
    a_right  = ax_e + A_W_M1;
    a_bottom = ay_e + A_H_M1;
    b_right  = bx_e + B_W_M1;
    b_bottom = by_e + B_H_M1;
    overlap  = (ax_e <= b_right)  && (bx_e <= a_right) &&
               (ay_e <= b_bottom) && (by_e <= a_bottom);
  end

endmodule

// File: rtl/hit_score_ctl.sv
// hit_score_ctl
// Consumes the in-flight shot position once per frame, decides hit / miss
// against the target, keeps the saturating score and miss count, and returns
// a one-cycle shot_done to the projectile controller.
//   clk   : pixel clock
//   rst   : asynchronous, active-low reset
//   bus   : slave side of hit_score_ctl_if (stream inputs, score outputs)
// All outputs come straight from flops.
module hit_score_ctl
  import game_pkg::*;
#(
  parameter int SHOT_W          = SHOT_W_DEF,
  parameter int SHOT_H          = SHOT_H_DEF,
  parameter int TARGET_W        = TARGET_W_DEF,
  parameter int TARGET_H        = TARGET_H_DEF,
  parameter int TOP_Y           = 1,
  parameter int SCORE_MAX       = 999,
  parameter int MAX_MISSES      = 5,
  parameter int HIT_HOLD_FRAMES = 30
) (
  input  logic            clk,
  input  logic            rst,
  hit_score_ctl_if.slave  bus
);

  localparam int CNT_W = $clog2(HIT_HOLD_FRAMES + 1);

  state_e             state_q, state_d;
  logic [11:0]        score_q, score_d;
  logic [3:0]         miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               hit_q, hit_d;
  logic               shot_done_q, shot_done_d;
  logic               hit_flash_q, hit_flash_d;
  logic               game_over_q, game_over_d;

  logic               overlap;
  logic [3:0]         miss_inc;

  rect_overlap #(
    .A_W (SHOT_W),
    .A_H (SHOT_H),
    .B_W (TARGET_W),
    .B_H (TARGET_H)
  ) u_overlap (
    .ax      (bus.shot_xpos),
    .ay      (bus.shot_ypos),
    .bx      (bus.target_xpos),
    .by      (bus.target_ypos),
    .overlap (overlap)
  );

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    miss_cnt_d  = miss_cnt_q;
    frame_cnt_d = frame_cnt_q;
    hit_d       = 1'b0;
    shot_done_d = 1'b0;
    hit_flash_d = hit_flash_q;
    game_over_d = game_over_q;
    miss_inc    = (miss_cnt_q == 4'd15) ? 4'd15 : miss_cnt_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        if (bus.shot_valid && !game_over_q) state_d = ST_ARMED;
      end

      // Hit is tested before top-of-screen so a shot that reaches the top
      // while touching the target scores instead of counting as a miss.
      ST_ARMED: begin
        if (bus.frame_tick && overlap) begin
          state_d     = ST_HOLD;
          score_d     = (score_q < 12'(SCORE_MAX)) ? score_q + 12'd1 : score_q;
          hit_d       = 1'b1;
          shot_done_d = 1'b1;
          hit_flash_d = 1'b1;
          frame_cnt_d = '0;
        end else if (bus.frame_tick && (bus.shot_ypos <= 12'(TOP_Y))) begin
          miss_cnt_d  = miss_inc;
          shot_done_d = 1'b1;
          if (miss_inc == 4'(MAX_MISSES)) begin
            state_d     = ST_OVER;
            game_over_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!bus.shot_valid) begin
          state_d = ST_IDLE;
        end
      end

      ST_HOLD: begin
        hit_flash_d = 1'b1;
        if (bus.frame_tick) begin
          if (frame_cnt_q == CNT_W'(HIT_HOLD_FRAMES - 1)) begin
            frame_cnt_d = '0;
            hit_flash_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      ST_OVER: begin
        game_over_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    // new_game overrides any decision taken on the same cycle.
    if (bus.new_game) begin
      state_d     = ST_IDLE;
      score_d     = '0;
      miss_cnt_d  = '0;
      frame_cnt_d = '0;
      hit_d       = 1'b0;
      shot_done_d = 1'b0;
      hit_flash_d = 1'b0;
      game_over_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      miss_cnt_q  <= '0;
      frame_cnt_q <= '0;
      hit_q       <= 1'b0;
      shot_done_q <= 1'b0;
      hit_flash_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      miss_cnt_q  <= miss_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      hit_q       <= hit_d;
      shot_done_q <= shot_done_d;
      hit_flash_q <= hit_flash_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.score     = score_q;
  assign bus.miss_cnt  = miss_cnt_q;
  assign bus.hit       = hit_q;
  assign bus.shot_done = shot_done_q;
  assign bus.hit_flash = hit_flash_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_hit_score_ctl.sv
// tb_hit_score_ctl
// Scenario tasks drive the stream; every hit/miss decision pushes its
// expected output snapshot onto a queue, and a monitor pops and compares it
// whenever the DUT raises hit or shot_done.
module tb_hit_score_ctl;
  import game_pkg::*;

  localparam int HOLD = 30;

  typedef struct packed {
    logic        hit;
    logic        done;
    logic        flash;
    logic        over;
    logic [11:0] score;
    logic [3:0]  miss;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  hit_score_ctl_if bus();

  hit_score_ctl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   exp_score = 0;
  int   exp_miss  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && (bus.hit === 1'b1 || bus.shot_done === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse hit=%0b shot_done=%0b score=%0d miss=%0d required=no pulse",
                 bus.hit, bus.shot_done, bus.score, bus.miss_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.hit, bus.shot_done, bus.hit_flash, bus.game_over, bus.score, bus.miss_cnt} !== mon_e) begin
          failures++;
          $display("FAIL pulse_event got hit=%0b done=%0b flash=%0b over=%0b score=%0d miss=%0d required hit=%0b done=%0b flash=%0b over=%0b score=%0d miss=%0d",
                   bus.hit, bus.shot_done, bus.hit_flash, bus.game_over, bus.score, bus.miss_cnt,
                   mon_e.hit, mon_e.done, mon_e.flash, mon_e.over, mon_e.score, mon_e.miss);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int sx, input int sy, input int tx, input int ty);
    bus.shot_xpos   = 12'(sx);
    bus.shot_ypos   = 12'(sy);
    bus.target_xpos = 12'(tx);
    bus.target_ypos = 12'(ty);
  endtask

  task automatic push_hit();
    if (exp_score < 999) exp_score++;
    exp_q.push_back({1'b1, 1'b1, 1'b1, 1'b0, 12'(exp_score), 4'(exp_miss)});
  endtask

  task automatic push_miss();
    if (exp_miss < 15) exp_miss++;
    exp_q.push_back({1'b0, 1'b1, 1'b0, (exp_miss == 5), 12'(exp_score), 4'(exp_miss)});
  endtask

  // Arm a shot, present one frame tick, then release shot_valid.
  task automatic shoot();
    bus.shot_valid = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b0;
    bus.shot_valid = 1'b0;
  endtask

  task automatic run_frames(input int n);
    bus.frame_tick = 1'b1;
    cyc(n);
    bus.frame_tick = 1'b0;
  endtask

  task automatic new_game_pulse();
    bus.new_game = 1'b1;
    cyc(1);
    bus.new_game = 1'b0;
    exp_score = 0;
    exp_miss  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.frame_tick = 1'b0;
    bus.shot_valid = 1'b0;
    bus.new_game   = 1'b0;
    set_pos(0, 0, 0, 0);
    cyc(2);
    checks++;
    if ({bus.score, bus.miss_cnt, bus.hit, bus.shot_done, bus.hit_flash, bus.game_over} !== 20'd0) begin
      failures++;
      $display("FAIL reset_values got score=%0d miss=%0d hit=%0b done=%0b flash=%0b over=%0b required all 0",
               bus.score, bus.miss_cnt, bus.hit, bus.shot_done, bus.hit_flash, bus.game_over);
    end
    rst = 1'b1;
    cyc(2);
    checks++;
    if ({bus.score, bus.miss_cnt, bus.hit_flash, bus.game_over} !== 18'd0) begin
      failures++;
      $display("FAIL post_reset got score=%0d miss=%0d flash=%0b over=%0b required all 0",
               bus.score, bus.miss_cnt, bus.hit_flash, bus.game_over);
    end
  endtask

  task automatic test_hit();
    set_pos(100, 200, 90, 190);
    push_hit();
    shoot();
    checks++;
    if (bus.score !== 12'd1) begin
      failures++;
      $display("FAIL hit_score got %0d required 1", bus.score);
    end
    run_frames(HOLD - 1);
    checks++;
    if (bus.hit_flash !== 1'b1) begin
      failures++;
      $display("FAIL flash_held got %0b required 1", bus.hit_flash);
    end
    run_frames(1);
    checks++;
    if (bus.hit_flash !== 1'b0) begin
      failures++;
      $display("FAIL flash_end got %0b required 0", bus.hit_flash);
    end
  endtask

  task automatic test_edge();
    set_pos(153, 200, 90, 190);
    push_hit();
    shoot();
    run_frames(HOLD);
    set_pos(154, 200, 90, 190);
    shoot();
    cyc(2);
    checks++;
    if (bus.score !== 12'(exp_score) || exp_q.size() != 0) begin
      failures++;
      $display("FAIL edge_no_hit got score=%0d pending=%0d required score=%0d pending=0",
               bus.score, exp_q.size(), exp_score);
    end
  endtask

  task automatic test_wrap();
    set_pos(5, 200, 4090, 190);
    shoot();
    cyc(2);
    checks++;
    if (bus.score !== 12'(exp_score)) begin
      failures++;
      $display("FAIL wrap_false_hit got score=%0d required %0d", bus.score, exp_score);
    end
    set_pos(4093, 200, 4090, 190);
    push_hit();
    shoot();
    run_frames(HOLD);
    checks++;
    if (bus.score !== 12'(exp_score) || bus.hit_flash !== 1'b0) begin
      failures++;
      $display("FAIL wrap_right_edge got score=%0d flash=%0b required score=%0d flash=0",
               bus.score, bus.hit_flash, exp_score);
    end
  endtask

  task automatic test_miss_game_over();
    new_game_pulse();
    checks++;
    if (bus.score !== 12'd0 || bus.miss_cnt !== 4'd0) begin
      failures++;
      $display("FAIL new_game_clear got score=%0d miss=%0d required 0 0", bus.score, bus.miss_cnt);
    end
    set_pos(500, 1, 90, 190);
    for (int i = 1; i <= 5; i++) begin
      push_miss();
      shoot();
      checks++;
      if (bus.miss_cnt !== 4'(i)) begin
        failures++;
        $display("FAIL miss_count got %0d required %0d", bus.miss_cnt, i);
      end
      cyc(1);
    end
    checks++;
    if (bus.game_over !== 1'b1) begin
      failures++;
      $display("FAIL game_over_set got %0b required 1", bus.game_over);
    end
    set_pos(100, 200, 90, 190);
    bus.shot_valid = 1'b1;
    run_frames(4);
    bus.shot_valid = 1'b0;
    cyc(1);
    checks++;
    if (bus.game_over !== 1'b1 || bus.score !== 12'd0 || bus.miss_cnt !== 4'd5) begin
      failures++;
      $display("FAIL over_ignores_shot got over=%0b score=%0d miss=%0d required 1 0 5",
               bus.game_over, bus.score, bus.miss_cnt);
    end
    new_game_pulse();
    checks++;
    if ({bus.score, bus.miss_cnt, bus.game_over, bus.hit_flash} !== 18'd0) begin
      failures++;
      $display("FAIL new_game_after_over got score=%0d miss=%0d over=%0b flash=%0b required all 0",
               bus.score, bus.miss_cnt, bus.game_over, bus.hit_flash);
    end
  endtask

  task automatic test_hit_at_top();
    set_pos(100, 1, 90, 0);
    push_hit();
    shoot();
    checks++;
    if (bus.miss_cnt !== 4'd0 || bus.score !== 12'd1) begin
      failures++;
      $display("FAIL hit_at_top got miss=%0d score=%0d required 0 1", bus.miss_cnt, bus.score);
    end
    run_frames(HOLD);
  endtask

  task automatic test_drop();
    set_pos(100, 200, 90, 190);
    bus.shot_valid = 1'b1;
    cyc(3);
    bus.shot_valid = 1'b0;
    cyc(2);
    run_frames(3);
    cyc(2);
    checks++;
    if (bus.score !== 12'(exp_score) || bus.miss_cnt !== 4'(exp_miss) || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drop_mid_flight got score=%0d miss=%0d pending=%0d required score=%0d miss=%0d pending=0",
               bus.score, bus.miss_cnt, exp_q.size(), exp_score, exp_miss);
    end
  endtask

  task automatic test_saturation();
    set_pos(100, 200, 90, 190);
    while (exp_score < 999) begin
      push_hit();
      shoot();
      run_frames(HOLD);
    end
    checks++;
    if (bus.score !== 12'd999) begin
      failures++;
      $display("FAIL score_reach_max got %0d required 999", bus.score);
    end
    push_hit();
    shoot();
    checks++;
    if (bus.score !== 12'd999) begin
      failures++;
      $display("FAIL score_saturate got %0d required 999", bus.score);
    end
    run_frames(HOLD);
  endtask

  task automatic test_reset_mid_hold();
    set_pos(100, 200, 90, 190);
    push_hit();
    shoot();
    run_frames(5);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.score, bus.miss_cnt, bus.hit, bus.shot_done, bus.hit_flash, bus.game_over} !== 20'd0) begin
      failures++;
      $display("FAIL async_reset got score=%0d miss=%0d hit=%0b done=%0b flash=%0b over=%0b required all 0",
               bus.score, bus.miss_cnt, bus.hit, bus.shot_done, bus.hit_flash, bus.game_over);
    end
    exp_score = 0;
    exp_miss  = 0;
    cyc(1);
    rst = 1'b1;
    run_frames(3);
    cyc(2);
    checks++;
    if (bus.hit_flash !== 1'b0 || bus.score !== 12'd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL after_reset_idle got flash=%0b score=%0d pending=%0d required 0 0 0",
               bus.hit_flash, bus.score, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_edge();
    test_wrap();
    test_miss_game_over();
    test_hit_at_top();
    test_drop();
    test_saturation();
    test_reset_mid_hold();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got %0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
